// File: rtl/reg_dump.sv
// Streams the contents of a register file out over a valid/ready channel.
// Each word is read live from the file: READ -> LATCH -> SEND per address, then a one-cycle DONE.
module reg_dump #(
    parameter int p_WORD_LEN      = 16,
    parameter int p_REG_ADDR_LEN  = 3,
    parameter int p_REG_FILE_SIZE = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic [p_REG_ADDR_LEN-1:0] o_rd_addr,
    input  logic [p_WORD_LEN-1:0]     i_rd_data,
    output logic [p_WORD_LEN-1:0]     o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_last,
    output logic                      o_done
);

    localparam logic [p_REG_ADDR_LEN-1:0] LAST_ADDR = p_REG_ADDR_LEN'(p_REG_FILE_SIZE - 1);
    localparam logic [p_REG_ADDR_LEN-1:0] ADDR_ONE  = p_REG_ADDR_LEN'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                      state_r;
    state_t                      state_next_s;
    logic [p_REG_ADDR_LEN-1:0]   rd_addr_r;
    logic [p_WORD_LEN-1:0]       data_r;
    logic                        valid_r;
    logic                        last_r;
    logic                        done_r;
    logic                        busy_r;
    logic                        xfer_s;
    logic                        at_last_s;

    assign xfer_s    = valid_r & i_ready;
    assign at_last_s = (rd_addr_r == LAST_ADDR);

    // Next-state decode; a start request is only honoured from IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_next_s = READ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ:  state_next_s = LATCH;
            LATCH: state_next_s = SEND;
            SEND: begin
                if (xfer_s) begin
                    if (at_last_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = READ;
                    end
                end else begin
                    state_next_s = SEND;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State and output registers; reset beats both start and an in-flight transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= IDLE;
            rd_addr_r <= '0;
            data_r    <= '0;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        rd_addr_r <= '0;
                    end
                end
                LATCH: begin
                    // Read data is registered in the file, so it is valid now.
                    data_r  <= i_rd_data;
                    valid_r <= 1'b1;
                    last_r  <= at_last_s;
                end
                SEND: begin
                    if (xfer_s) begin
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        if (!at_last_s) begin
                            rd_addr_r <= rd_addr_r + ADDR_ONE;
                        end
                    end
                end
                default: begin
                    rd_addr_r <= rd_addr_r;
                end
            endcase
        end
    end

    assign o_busy    = busy_r;
    assign o_rd_addr = rd_addr_r;
    assign o_data    = data_r;
    assign o_valid   = valid_r;
    assign o_last    = last_r;
    assign o_done    = done_r;

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: a registered-read register file model feeds the DUT,
// a negedge monitor logs transfers, and the initial block checks outcomes against hand-computed values.
module tb_reg_dump;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic        o_busy;
    logic [2:0]  o_rd_addr;
    logic [15:0] i_rd_data;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_last;
    logic        o_done;

    logic [15:0] rf [8];
    logic [15:0] xq [$];
    logic        lq [$];
    int          cq [$];
    int          cyc;
    int          base;
    int          done_cnt;
    int          done_cyc;
    int          busy_cnt;
    int          checks;
    int          errors;

    reg_dump #(
        .p_WORD_LEN(16),
        .p_REG_ADDR_LEN(3),
        .p_REG_FILE_SIZE(8)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_start(i_start),
        .o_busy(o_busy),
        .o_rd_addr(o_rd_addr),
        .i_rd_data(i_rd_data),
        .o_data(o_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_last(o_last),
        .o_done(o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Register file read port with one cycle of latency.
    always @(posedge i_clk) i_rd_data <= rf[o_rd_addr];

    always @(posedge i_clk) cyc <= cyc + 1;

    // Monitor on the falling edge: log transfers, done pulses and busy cycles.
    always @(negedge i_clk) begin
        if (o_valid && i_ready) begin
            xq.push_back(o_data);
            lq.push_back(o_last);
            cq.push_back(cyc - base + 1);
        end
        if (o_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc - base + 1;
        end
        if (o_busy) busy_cnt = busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    // Pulses i_start for one edge; afterwards the bench sits in cycle 1 of the dump.
    task automatic start_dump();
        xq.delete();
        lq.delete();
        cq.delete();
        done_cnt = 0;
        done_cyc = 0;
        busy_cnt = 0;
        i_start  = 1'b1;
        @(posedge i_clk);
        #2;
        i_start = 1'b0;
        base    = cyc;
    endtask

    task automatic load_rf();
        for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h1111);
    endtask

    task automatic chk_dump(input string tag, input int stall_from, input int stall_len);
        chk({tag, "_count"}, 32'(xq.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_last"}, {31'd0, lq[k]}, {31'd0, (k == 7)});
            chk({tag, "_cyc"}, 32'(cq[k]), 32'(3 * (k + 1) + ((k >= stall_from) ? stall_len : 0)));
        end
    endtask

    initial begin
        cyc      = 0;
        base     = 0;
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        done_cyc = 0;
        busy_cnt = 0;
        i_rst    = 1'b1;
        i_start  = 1'b0;
        i_ready  = 1'b1;
        load_rf();
        step(2);
        i_rst = 1'b0;
        step(1);

        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_last", {31'd0, o_last}, 32'd0);
        chk("rst_addr", {29'd0, o_rd_addr}, 32'd0);
        chk("rst_data", {16'd0, o_data}, 32'd0);

        // Full dump with i_ready held high.
        start_dump();
        chk("c1_busy", {31'd0, o_busy}, 32'd1);
        chk("c1_addr", {29'd0, o_rd_addr}, 32'd0);
        chk("c1_valid", {31'd0, o_valid}, 32'd0);
        step(2);
        chk("c3_valid", {31'd0, o_valid}, 32'd1);
        chk("c3_data", {16'd0, o_data}, 32'h0000);
        step(23);
        chk("full_idle", {31'd0, o_busy}, 32'd0);
        chk("full_done_cnt", 32'(done_cnt), 32'd1);
        chk("full_done_cyc", 32'(done_cyc), 32'd25);
        chk("full_busy_cnt", 32'(busy_cnt), 32'd25);
        for (int k = 0; k < 8; k++) chk("full_word", {16'd0, xq[k]}, 32'(k * 32'h1111));
        chk_dump("full", 8, 0);

        // Backpressure on word 3 for five cycles.
        start_dump();
        step(11);
        i_ready = 1'b0;
        chk("bp_data_a", {16'd0, o_data}, 32'h3333);
        chk("bp_addr_a", {29'd0, o_rd_addr}, 32'd3);
        step(4);
        chk("bp_data_b", {16'd0, o_data}, 32'h3333);
        chk("bp_addr_b", {29'd0, o_rd_addr}, 32'd3);
        chk("bp_valid_b", {31'd0, o_valid}, 32'd1);
        chk("bp_last_b", {31'd0, o_last}, 32'd0);
        step(1);
        i_ready = 1'b1;
        step(14);
        chk("bp_idle", {31'd0, o_busy}, 32'd0);
        chk("bp_done_cyc", 32'(done_cyc), 32'd30);
        chk("bp_busy_cnt", 32'(busy_cnt), 32'd30);
        for (int k = 0; k < 8; k++) chk("bp_word", {16'd0, xq[k]}, 32'(k * 32'h1111));
        chk_dump("bp", 3, 5);

        // Start held high through the dump must be ignored.
        start_dump();
        step(1);
        i_start = 1'b1;
        step(24);
        i_start = 1'b0;
        step(1);
        chk("ign_idle", {31'd0, o_busy}, 32'd0);
        chk("ign_done_cnt", 32'(done_cnt), 32'd1);
        chk("ign_count", 32'(xq.size()), 32'd8);

        // Reset during SEND of word 4, with i_ready high.
        start_dump();
        step(14);
        chk("mid_pre_data", {16'd0, o_data}, 32'h4444);
        i_rst = 1'b1;
        step(1);
        i_rst = 1'b0;
        chk("mid_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_addr", {29'd0, o_rd_addr}, 32'd0);
        chk("mid_data", {16'd0, o_data}, 32'd0);
        chk("mid_last", {31'd0, o_last}, 32'd0);
        step(4);
        chk("mid_no_done", 32'(done_cnt), 32'd0);
        chk("mid_still_idle", {31'd0, o_busy}, 32'd0);

        // Fresh dump after reset, with r5 rewritten early in the dump.
        start_dump();
        step(4);
        rf[5] = 16'hABCD;
        step(21);
        chk("live_idle", {31'd0, o_busy}, 32'd0);
        chk("live_w0", {16'd0, xq[0]}, 32'h0000);
        chk("live_w4", {16'd0, xq[4]}, 32'h4444);
        chk("live_w5", {16'd0, xq[5]}, 32'hABCD);
        chk("live_w7", {16'd0, xq[7]}, 32'h7777);
        chk("live_done_cyc", 32'(done_cyc), 32'd25);
        chk_dump("live", 8, 0);

        // Start coincident with reset stays idle.
        i_start = 1'b1;
        i_rst   = 1'b1;
        step(1);
        i_start = 1'b0;
        i_rst   = 1'b0;
        chk("co_busy", {31'd0, o_busy}, 32'd0);
        chk("co_valid", {31'd0, o_valid}, 32'd0);
        step(3);
        chk("co_busy_later", {31'd0, o_busy}, 32'd0);
        chk("co_done", {31'd0, o_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
